reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
- Upstream master for the register block: accepts host commands, queues them, and drives the req/rd_wr/addr/write_val bus one transaction at a time.
- Waits for ack, captures read_val, and returns a response to the host.
- A timeout guards against a missing ack.
- Sits between the host/CPU interface and the register bank.

Parameters:
ADDR_SIZE_P, 4, register address width (matches register bank)
CMD_DEPTH_P, 4, command FIFO depth (power of 2, >=2)
TIMEOUT_P, 16, cycles to wait for ack after req before declaring error (>=2)

Ports:
clk  input  1  clock
reset_L  input  1  asynchronous active-low reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  FIFO can accept a command
cmd_rd_wr  input  1  1=read, 0=write
cmd_addr  input  ADDR_SIZE_P  target register address
cmd_wdata  input  32  write data (ignored for reads)
rsp_valid  output  1  response available
rsp_ready  input  1  host accepts response
rsp_rdata  output  32  read data (0 for writes and errors)
rsp_err  output  1  transaction timed out
req  output  1  register bus request, single-cycle pulse
rd_wr  output  1  register bus direction, 1=read
addr  output  ADDR_SIZE_P  register bus address
write_val  output  32  register bus write data
read_val  input  32  register bus read data, valid with ack
ack  input  1  register bus acknowledge

Behaviour:
- Interface decision: one clock, clk. Reset is reset_L, asynchronous and active-low.
- Reset values:
  - req=0, rd_wr=0, addr=0, write_val=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - cmd_ready=1.
  - FIFO empty; FSM in IDLE; timeout counter 0.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - Push while full is impossible by construction.
  - Simultaneous push and pop when full is not allowed, since cmd_ready=0.
  - Simultaneous push and pop when non-full: both occur and occupancy is unchanged.
  - Pointers wrap modulo CMD_DEPTH_P.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into bus regs (rd_wr, addr, write_val) and go to ISSUE.
  - ISSUE: req=1 for exactly this cycle; clear counter; go to WAIT.
  - WAIT: req=0.
    - If ack: capture read_val into rsp_rdata when rd_wr=1 (else 0), set rsp_err=0, go to RESP.
    - Else increment counter. When counter reaches TIMEOUT_P-1 with no ack: rsp_rdata=0, rsp_err=1, go to RESP.
  - RESP: rsp_valid=1; hold rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Latency:
  - Command accepted in cycle N (empty FIFO, idle FSM): req pulses in cycle N+2.
  - Ack at N+3: rsp_valid at N+4.
- addr, rd_wr and write_val stay stable from ISSUE through RESP exit.
- Only one outstanding transaction at a time.
- Ack in ISSUE (same cycle as req) is ignored. Ack in IDLE/RESP is ignored.
- Ack arriving on the same cycle the timeout fires: ack wins (rsp_err=0).
- Reset mid-transaction:
  - FIFO is flushed and outputs return to reset values immediately (async).
  - A pending response is lost.

Optional Feature:
- Macro: REG_BUS_MASTER_RETRY_EN.
- When defined:
  - On first timeout, return to ISSUE and re-pulse req with identical addr/rd_wr/write_val.
  - rsp_err=1 only after the second timeout.
  - Extra output rsp_retry (1 bit) = 1 in RESP if a retry occurred; reset 0.
- When undefined: first timeout reports rsp_err=1; no rsp_retry port.

Decomposition:
- Shared package reg_bus_pkg:
  - typedef enum state_e {IDLE, ISSUE, WAIT, RESP}.
  - typedef struct reg_cmd_t {rd_wr, addr, wdata}.
  - Constants RD=1'b1 and WR=1'b0.
- Sub-module reg_cmd_fifo: synchronous FIFO of reg_cmd_t, params CMD_DEPTH_P and width; ports push/pop/full/empty.

Test Plan:
- Write then read: cmd (wr, addr=1, wdata=0x0000_0005), then cmd (rd, addr=1). Responder acks 1 cycle after req with read_val=0x5 on the read → responses {rdata=0, err=0} then {rdata=0x5, err=0}; req pulses are 1 cycle wide.
- FIFO full: push 4 commands while responder is stalled (no ack) → cmd_ready=0 after the 4th push. A 5th cmd_valid is not accepted. cmd_ready=1 again the cycle after the first pop.
- Timeout: read addr=2, no ack ever → rsp_valid exactly TIMEOUT_P cycles after the req pulse, rsp_err=1, rsp_rdata=0. With REG_BUS_MASTER_RETRY_EN: two req pulses, and rsp_retry=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read response with rdata=0xA5A5_A5A5 → rsp_valid, rsp_rdata and bus outputs stable. No new req until rsp_ready=1.
- Ack/timeout collision: ack asserted with read_val=0x3 exactly on the timeout cycle → rsp_err=0, rsp_rdata=0x3.
- Reset mid-WAIT: reset_L=0 asynchronously with 2 commands queued → req, rsp_valid and FIFO cleared immediately. After release, no stale req is issued.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register bus master and its command FIFO.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // Widest supported register address; narrower buses zero-extend into it.
  localparam int unsigned ADDR_MAX_W = 16;

  typedef struct packed {
    logic                  rd_wr;
    logic [ADDR_MAX_W-1:0] addr;
    logic [31:0]           wdata;
  } reg_cmd_t;

  localparam int unsigned CMD_W = $bits(reg_cmd_t);

  // Writes never return data to the host.
  function automatic logic [31:0] rsp_data(input logic rd_wr, input logic [31:0] read_val);
    return (rd_wr == RD) ? read_val : 32'h0;
  endfunction

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through head and async active-low reset.
module reg_cmd_fifo #(
  parameter int unsigned CMD_DEPTH_P = 4,
  parameter int unsigned WIDTH_P     = 1
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               push,
  input  logic [WIDTH_P-1:0] push_data,
  input  logic               pop,
  output logic [WIDTH_P-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PtrW = (CMD_DEPTH_P > 1) ? $clog2(CMD_DEPTH_P) : 1;
  localparam logic [PtrW:0] FullCnt = CMD_DEPTH_P[PtrW:0];

  logic [WIDTH_P-1:0] mem_q [CMD_DEPTH_P];
  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [PtrW:0]      count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full     = (count_q == FullCnt);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rptr_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/reg_bus_master.sv
// Host-to-register-bus master: queues commands, runs one bus transaction at a time with an
// ack timeout. Optional REG_BUS_MASTER_RETRY_EN re-issues once after the first timeout.
module reg_bus_master #(
  parameter int unsigned ADDR_SIZE_P = 4,
  parameter int unsigned CMD_DEPTH_P = 4,
  parameter int unsigned TIMEOUT_P   = 16
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rd_wr,
  input  logic [ADDR_SIZE_P-1:0] cmd_addr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
`ifdef REG_BUS_MASTER_RETRY_EN
  output logic                   rsp_retry,
`endif
  output logic                   req,
  output logic                   rd_wr,
  output logic [ADDR_SIZE_P-1:0] addr,
  output logic [31:0]            write_val,
  input  logic [31:0]            read_val,
  input  logic                   ack
);

  import reg_bus_pkg::*;

  localparam int unsigned CntW = (TIMEOUT_P > 2) ? $clog2(TIMEOUT_P) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_P - 1);

  state_e                 state_q, state_d;
  logic                   rd_wr_q, rd_wr_d;
  logic [ADDR_SIZE_P-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
`ifdef REG_BUS_MASTER_RETRY_EN
  logic                   retried_q, retried_d;
`endif

  reg_cmd_t cmd_in;
  reg_cmd_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     unused_head_addr;

  assign cmd_in.rd_wr = cmd_rd_wr;
  assign cmd_in.addr  = ADDR_MAX_W'(cmd_addr);
  assign cmd_in.wdata = cmd_wdata;

  assign cmd_ready        = !fifo_full;
  assign fifo_push        = cmd_valid && cmd_ready;
  assign unused_head_addr = ^head.addr;

  reg_cmd_fifo #(
    .CMD_DEPTH_P (CMD_DEPTH_P),
    .WIDTH_P     (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (fifo_push),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    rd_wr_d  = rd_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
`ifdef REG_BUS_MASTER_RETRY_EN
    retried_d = retried_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rd_wr_d  = head.rd_wr;
          addr_d   = head.addr[ADDR_SIZE_P-1:0];
          wdata_d  = head.wdata;
          state_d  = ISSUE;
`ifdef REG_BUS_MASTER_RETRY_EN
          retried_d = 1'b0;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (ack) begin
          rdata_d = rsp_data(rd_wr_q, read_val);
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntLast) begin
`ifdef REG_BUS_MASTER_RETRY_EN
            if (!retried_q) begin
              retried_d = 1'b1;
              state_d   = ISSUE;
            end else begin
              rdata_d = '0;
              err_d   = 1'b1;
              state_d = RESP;
            end
`else
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
`endif
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      rd_wr_q <= WR;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_wr_q <= rd_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef REG_BUS_MASTER_RETRY_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      retried_q <= 1'b0;
    end else begin
      retried_q <= retried_d;
    end
  end

  assign rsp_retry = (state_q == RESP) && retried_q;
`endif

  assign req       = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rd_wr     = rd_wr_q;
  assign addr      = addr_q;
  assign write_val = wdata_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed self-checking bench for reg_bus_master (default and REG_BUS_MASTER_RETRY_EN builds).
module tb_reg_bus_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO = 16;
`ifdef REG_BUS_MASTER_RETRY_EN
  localparam int RspDelay = 2 * TO;
  localparam int ReqPerTo = 2;
`else
  localparam int RspDelay = TO;
  localparam int ReqPerTo = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
`ifdef REG_BUS_MASTER_RETRY_EN
  logic          rsp_retry;
`endif
  logic          req;
  logic          rd_wr;
  logic [AW-1:0] addr;
  logic [31:0]   write_val;
  logic [31:0]   read_val = '0;
  logic          ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cnt = 0;
  int rsp_cnt = 0;
  logic        resp_en = 1'b0;
  logic [31:0] resp_val = '0;

  reg_bus_master #(
    .ADDR_SIZE_P (AW),
    .CMD_DEPTH_P (DEPTH),
    .TIMEOUT_P   (TO)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd_wr (cmd_rd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
`ifdef REG_BUS_MASTER_RETRY_EN
    .rsp_retry (rsp_retry),
`endif
    .req       (req),
    .rd_wr     (rd_wr),
    .addr      (addr),
    .write_val (write_val),
    .read_val  (read_val),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (req) req_cnt++;
    if (rsp_valid && rsp_ready) rsp_cnt++;
  end

  // Responder: acks one cycle after a req pulse.
  always @(negedge clk) begin
    if (resp_en && req) begin
      @(posedge clk);
      #1;
      ack = 1'b1;
      read_val = resp_val;
      @(posedge clk);
      #1;
      ack = 1'b0;
      read_val = '0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input logic rd, input logic [AW-1:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_rd_wr = rd;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_cmd: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req && n < limit);
    if (!req) begin
      checks++;
      errors++;
      $display("FAIL wait_req: req=%b after %0d cycles, required 1", req, n);
    end
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < limit);
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_rsp: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  task automatic test_reset();
    #2 reset_L = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b, expected 0", req);
    end
    checks++;
    if ({rd_wr, addr, write_val} !== {1'b0, 4'h0, 32'h0}) begin
      errors++; $display("FAIL reset_bus: got rd_wr=%b addr=%h wv=%h, expected 0", rd_wr, addr, write_val);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid);
    end
    checks++;
    if ({rsp_rdata, rsp_err} !== 33'h0) begin
      errors++; $display("FAIL reset_rsp_data: got rdata=%h err=%b, expected 0", rsp_rdata, rsp_err);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready);
    end
`ifdef REG_BUS_MASTER_RETRY_EN
    checks++;
    if (rsp_retry !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_retry: got %b, expected 0", rsp_retry);
    end
`endif
    @(posedge clk);
    #1 reset_L = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req, rsp_valid, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_idle: got req/rsp_valid/cmd_ready=%b, expected 001", {req, rsp_valid, cmd_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    resp_en = 1'b1;
    resp_val = 32'h5;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_rd_wr = 1'b0;
    cmd_addr  = 4'd1;
    cmd_wdata = 32'h0000_0005;
    @(negedge clk);              // cycle N
    @(posedge clk);
    #1;
    cmd_rd_wr = 1'b1;
    cmd_wdata = 32'h0;
    @(negedge clk);              // N+1
    checks++;
    if (req !== 1'b0) begin
      errors++; $display("FAIL wr_latency_n1: req got %b, expected 0", req);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);              // N+2
    checks++;
    if ({req, rd_wr, addr, write_val} !== {1'b1, 1'b0, 4'd1, 32'h5}) begin
      errors++; $display("FAIL wr_issue: got req=%b rd_wr=%b addr=%h wv=%h, expected 1 0 1 5", req, rd_wr, addr, write_val);
    end
    @(negedge clk);              // N+3
    checks++;
    if (req !== 1'b0) begin
      errors++; $display("FAIL wr_req_width: req got %b, expected 0", req);
    end
    @(negedge clk);              // N+4
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL wr_rsp: got valid=%b rdata=%h err=%b, expected 1 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    wait_req(10);
    checks++;
    if ({rd_wr, addr} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL rd_issue: got rd_wr=%b addr=%h, expected 1 1", rd_wr, addr);
    end
    wait_rsp(10);
    checks++;
    if ({rsp_rdata, rsp_err} !== {32'h5, 1'b0}) begin
      errors++; $display("FAIL rd_rsp: got rdata=%h err=%b, expected 5 0", rsp_rdata, rsp_err);
    end
    @(posedge clk);
    #1 resp_en = 1'b0;
  endtask

  task automatic test_fifo_full();
    int base;
    int n;
    rsp_ready = 1'b1;
    resp_en = 1'b0;
    base = rsp_cnt;
    send_cmd(1'b1, 4'hA, 32'h0);
    wait_req(10);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      send_cmd(1'b0, AW'(i), 32'h100 + i);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_after_4: cmd_ready got %b, expected 0", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_rd_wr = 1'b0;
    cmd_addr  = 4'd5;
    cmd_wdata = 32'h105;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_hold: cmd_ready got %b, expected 0", cmd_ready);
    end
    cmd_valid = 1'b0;
    wait_rsp(RspDelay + 10);
    checks++;
    if ({rsp_err, cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL full_first_rsp: got err=%b cmd_ready=%b, expected 1 0", rsp_err, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_pop_cycle: cmd_ready got %b, expected 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if ({req, cmd_ready} !== 2'b11) begin
      errors++; $display("FAIL full_after_pop: got req=%b cmd_ready=%b, expected 1 1", req, cmd_ready);
    end
    n = 0;
    while (rsp_cnt != base + 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    checks++;
    if (rsp_cnt - base != 5) begin
      errors++; $display("FAIL full_rsp_count: got %0d responses, expected 5", rsp_cnt - base);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int base_req;
    int t0;
    int t1;
    rsp_ready = 1'b1;
    resp_en = 1'b0;
    base_req = req_cnt;
    send_cmd(1'b1, 4'd2, 32'h0);
    wait_req(10);
    t0 = cyc;
    wait_rsp(RspDelay + 10);
    t1 = cyc;
    checks++;
    if (t1 - t0 != RspDelay) begin
      errors++; $display("FAIL to_latency: got %0d cycles, expected %0d", t1 - t0, RspDelay);
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL to_rsp: got err=%b rdata=%h, expected 1 0", rsp_err, rsp_rdata);
    end
    checks++;
    if ({rd_wr, addr} !== {1'b1, 4'd2}) begin
      errors++; $display("FAIL to_bus_hold: got rd_wr=%b addr=%h, expected 1 2", rd_wr, addr);
    end
    checks++;
    if (req_cnt - base_req != ReqPerTo) begin
      errors++; $display("FAIL to_req_pulses: got %0d, expected %0d", req_cnt - base_req, ReqPerTo);
    end
`ifdef REG_BUS_MASTER_RETRY_EN
    checks++;
    if (rsp_retry !== 1'b1) begin
      errors++; $display("FAIL to_retry_flag: got %b, expected 1", rsp_retry);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int base_req;
    rsp_ready = 1'b0;
    resp_en = 1'b1;
    resp_val = 32'hA5A5_A5A5;
    send_cmd(1'b1, 4'd3, 32'h0);
    send_cmd(1'b0, 4'd4, 32'hDEAD_BEEF);
    wait_rsp(20);
    base_req = req_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, rd_wr, addr, write_val} !==
          {1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1, 4'd3, 32'h0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b rd_wr=%b addr=%h wv=%h, expected 1 a5a5a5a5 0 1 3 0",
                 i, rsp_valid, rsp_rdata, rsp_err, rd_wr, addr, write_val);
      end
    end
    checks++;
    if (req_cnt != base_req) begin
      errors++; $display("FAIL bp_no_req: got %0d new req, expected 0", req_cnt - base_req);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_req(10);
    checks++;
    if ({rd_wr, addr, write_val} !== {1'b0, 4'd4, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL bp_next_issue: got rd_wr=%b addr=%h wv=%h, expected 0 4 deadbeef", rd_wr, addr, write_val);
    end
    wait_rsp(10);
    checks++;
    if ({rsp_rdata, rsp_err} !== {32'h0, 1'b0}) begin
      errors++; $display("FAIL bp_wr_rsp: got rdata=%h err=%b, expected 0 0", rsp_rdata, rsp_err);
    end
    @(posedge clk);
    #1 resp_en = 1'b0;
  endtask

  task automatic test_collision();
    rsp_ready = 1'b1;
    resp_en = 1'b0;
    send_cmd(1'b1, 4'd5, 32'h0);
    wait_req(10);
    repeat (TO - 1) @(posedge clk);
    #1;
    ack = 1'b1;
    read_val = 32'h3;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL col_pre: rsp_valid got %b, expected 0", rsp_valid);
    end
    @(posedge clk);
    #1;
    ack = 1'b0;
    read_val = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h3}) begin
      errors++; $display("FAIL col_rsp: got valid=%b err=%b rdata=%h, expected 1 0 3", rsp_valid, rsp_err, rsp_rdata);
    end
`ifdef REG_BUS_MASTER_RETRY_EN
    checks++;
    if (rsp_retry !== 1'b0) begin
      errors++; $display("FAIL col_retry_flag: got %b, expected 0", rsp_retry);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int base_req;
    int base_rsp;
    rsp_ready = 1'b1;
    resp_en = 1'b0;
    send_cmd(1'b0, 4'd7, 32'h1);
    send_cmd(1'b0, 4'd8, 32'h2);
    send_cmd(1'b0, 4'd9, 32'h3);
    repeat (3) @(negedge clk);
    checks++;
    if ({addr, write_val, rsp_valid} !== {4'd7, 32'h1, 1'b0}) begin
      errors++; $display("FAIL rst_mid_pre: got addr=%h wv=%h valid=%b, expected 7 1 0", addr, write_val, rsp_valid);
    end
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if ({req, rsp_valid, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL rst_mid_ctrl: got req/rsp_valid/cmd_ready=%b, expected 001", {req, rsp_valid, cmd_ready});
    end
    checks++;
    if ({rd_wr, addr, write_val, rsp_rdata, rsp_err} !== '0) begin
      errors++; $display("FAIL rst_mid_bus: got addr=%h wv=%h rdata=%h err=%b, expected 0", addr, write_val, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    base_req = req_cnt;
    base_rsp = rsp_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (req_cnt != base_req || rsp_cnt != base_rsp) begin
      errors++; $display("FAIL rst_mid_stale: got %0d req %0d rsp after reset, expected 0 0", req_cnt - base_req, rsp_cnt - base_rsp);
    end
    @(posedge clk);
    #1;
    resp_en = 1'b1;
    resp_val = 32'h1234_5678;
    send_cmd(1'b1, 4'd6, 32'h0);
    wait_rsp(20);
    checks++;
    if ({rsp_rdata, rsp_err, addr} !== {32'h1234_5678, 1'b0, 4'd6}) begin
      errors++; $display("FAIL rst_mid_after: got rdata=%h err=%b addr=%h, expected 12345678 0 6", rsp_rdata, rsp_err, addr);
    end
    @(posedge clk);
    #1 resp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fifo_full();
    test_timeout();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
